// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding control for the 5-stage pipeline.
// Handles load-use stall, multi-cycle scoreboard, redirect flush and EX forwarding selects.
module hazard_fwd_ctrl #(
    parameter int AW           = 5,
    parameter int NUM_SRC      = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [NUM_SRC*AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]   id_rs_used,
    input  logic                 id_mc,
    input  logic [AW-1:0]        ex_rd,
    input  logic                 ex_regwrite,
    input  logic                 ex_memread,
    input  logic [AW-1:0]        mem_rd,
    input  logic                 mem_regwrite,
    input  logic                 mc_done,
    input  logic                 redirect,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic [NUM_SRC*2-1:0] fwd_sel,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int FW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLOAD = FW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]          state;
    logic [FW-1:0]       fcnt;
    logic [2**AW-1:0]    pending;
    logic                mc_busy;
    logic                mc_in_ex;
    logic [NUM_SRC-1:0]  lu_v;
    logic [NUM_SRC-1:0]  sb_v;
    logic [NUM_SRC*2-1:0] fwd_next;
    logic                load_use;
    logic                sb_hit;
    logic                mc_struct;
    logic                flushing;
    logic                stall;
    logic                advance;
    logic                issue;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [AW-1:0] rs;
        logic          use_i;
        logic          ex_m;
        logic          mem_m;
        logic          ex_load;
        assign rs      = id_rs[i*AW +: AW];
        assign use_i   = id_valid && id_rs_used[i] && (rs != '0);
        assign ex_m    = use_i && (rs == ex_rd);
        assign mem_m   = use_i && (rs == mem_rd);
        assign ex_load = ex_m && ex_regwrite && ex_memread;
        assign lu_v[i] = ex_load;
        // mc op sitting in EX has not reached the pending vector yet
        assign sb_v[i] = use_i && (pending[rs] || (mc_in_ex && rs == ex_rd));
        assign fwd_next[2*i +: 2] =
            (ex_m && ex_regwrite && !ex_memread) ? 2'b01 :
            (!ex_load && mem_regwrite && mem_m)  ? 2'b10 : 2'b00;
    end

    assign load_use  = |lu_v;
    assign sb_hit    = |sb_v;
    assign mc_struct = id_valid && id_mc && mc_busy;
    assign flushing  = redirect || (state == FLUSH);
    assign stall     = (state == RUN) && !redirect && (load_use || sb_hit || mc_struct);
    assign advance   = !stall && !flushing;
    assign issue     = advance && id_valid && id_mc;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (flushing) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            fcnt      <= '0;
            pending   <= '0;
            mc_busy   <= 1'b0;
            mc_in_ex  <= 1'b0;
            fwd_sel   <= '0;
            stall_cnt <= '0;
        end else begin
            if (redirect) begin
                if (FLUSH_CYCLES > 1) begin
                    state <= FLUSH;
                    fcnt  <= FLOAD;
                end
            end else if (state == FLUSH) begin
                if (fcnt == '0) begin
                    state <= RUN;
                end else begin
                    fcnt <= fcnt - 1'b1;
                end
            end

            fwd_sel <= advance ? fwd_next : '0;

            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            // done retires the old op before the one in EX claims its rd
            if (mc_done || (mc_in_ex && ex_rd != '0)) begin
                pending <= (mc_done ? '0 : pending)
                         | ((mc_in_ex && ex_rd != '0) ? (2**AW)'(1) << ex_rd : '0);
            end
            mc_in_ex <= issue;
            if (issue) begin
                mc_busy <= 1'b1;
            end else if (mc_done) begin
                mc_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: vector table plus hand-written
// multi-cycle sequences (scoreboard, redirect flush, counter saturation, reset).
module tb_hazard_fwd_ctrl;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid;
    logic [NS*AW-1:0] id_rs;
    logic [NS-1:0] id_rs_used;
    logic          id_mc;
    logic [AW-1:0] ex_rd;
    logic          ex_regwrite;
    logic          ex_memread;
    logic [AW-1:0] mem_rd;
    logic          mem_regwrite;
    logic          mc_done;
    logic          redirect;
    logic          pc_en;
    logic          if_id_en;
    logic          if_id_flush;
    logic          id_ex_bubble;
    logic [NS*2-1:0] fwd_sel;
    logic [CW-1:0] stall_cnt;

    int n_pass = 0;
    int n_total = 0;
    int exp_cnt = 0;

    hazard_fwd_ctrl #(
        .AW(AW), .NUM_SRC(NS), .FLUSH_CYCLES(2), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_mc(id_mc), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mc_done(mc_done),
        .redirect(redirect), .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [1:0] used;
        logic [4:0] exrd;
        logic       exw;
        logic       exm;
        logic [4:0] memrd;
        logic       memw;
        logic       e_stall;
        logic [3:0] e_fwd;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // control outputs packed as {pc_en, if_id_en, if_id_flush, id_ex_bubble}
    task automatic ctl(input string name, input logic [3:0] exp);
        chk(name, int'({pc_en, if_id_en, if_id_flush, id_ex_bubble}), int'(exp));
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [1:0] u, input logic [4:0] er, input logic ew,
                         input logic em, input logic [4:0] mr, input logic mw);
        id_valid = v;
        id_rs = {r2, r1};
        id_rs_used = u;
        ex_rd = er;
        ex_regwrite = ew;
        ex_memread = em;
        mem_rd = mr;
        mem_regwrite = mw;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        id_mc = 1'b0;
        mc_done = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        //                valid rs1 rs2 used exrd exw exm memrd memw stall fwd
        vt[0]  = '{1'b1, 5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0001};
        vt[1]  = '{1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000};
        vt[2]  = '{1'b1, 5'd0, 5'd7, 2'b10, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 4'b0000};
        vt[3]  = '{1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 4'b1000};
        vt[4]  = '{1'b1, 5'd3, 5'd0, 2'b01, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 4'b0001};
        vt[5]  = '{1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 4'b0010};
        vt[6]  = '{1'b1, 5'd4, 5'd4, 2'b00, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 4'b0000};
        vt[7]  = '{1'b0, 5'd4, 5'd4, 2'b11, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 4'b0000};
        vt[8]  = '{1'b1, 5'd3, 5'd0, 2'b01, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 4'b0000};
        vt[9]  = '{1'b1, 5'd0, 5'd4, 2'b10, 5'd4, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 4'b1000};
        vt[10] = '{1'b1, 5'd5, 5'd6, 2'b11, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 4'b1001};
        vt[11] = '{1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 4'b0000};

        #2;
        ctl("reset_ctl", 4'b0001);
        chk("reset_fwd", int'(fwd_sel), 0);
        chk("reset_cnt", int'(stall_cnt), 0);
        tick();
        rst_n = 1'b1;
        #1;
        ctl("run_idle", 4'b1100);

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].valid, vt[i].rs1, vt[i].rs2, vt[i].used, vt[i].exrd,
                  vt[i].exw, vt[i].exm, vt[i].memrd, vt[i].memw);
            #1;
            ctl($sformatf("vec%0d_ctl", i), vt[i].e_stall ? 4'b0001 : 4'b1100);
            if (vt[i].e_stall) exp_cnt++;
            tick();
            chk($sformatf("vec%0d_fwd", i), int'(fwd_sel), int'(vt[i].e_fwd));
        end
        chk("table_cnt", int'(stall_cnt), exp_cnt);

        // multi-cycle op rd=9, consumer waits for mc_done
        idle();
        id_valid = 1'b1;
        id_mc = 1'b1;
        #1;
        ctl("mc_issue", 4'b1100);
        tick();
        id_mc = 1'b0;
        drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        ctl("mc_in_ex_stall", 4'b0001);
        tick();
        drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        ctl("mc_pend_stall", 4'b0001);
        tick();
        mc_done = 1'b1;
        #1;
        ctl("mc_done_stall", 4'b0001);
        tick();
        mc_done = 1'b0;
        #1;
        ctl("mc_release", 4'b1100);
        tick();
        exp_cnt += 3;

        // second mc op stalls on busy unit
        idle();
        id_valid = 1'b1;
        id_mc = 1'b1;
        #1;
        ctl("mc2_issue", 4'b1100);
        tick();
        #1;
        ctl("mc2_struct", 4'b0001);
        tick();
        mc_done = 1'b1;
        #1;
        ctl("mc2_done_cycle", 4'b0001);
        tick();
        mc_done = 1'b0;
        #1;
        ctl("mc2_advance", 4'b1100);
        tick();
        idle();
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        exp_cnt += 2;
        chk("mc_cnt", int'(stall_cnt), exp_cnt);

        // redirect with load-use in the same cycle
        drive(1'b1, 5'd0, 5'd7, 2'b10, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0);
        redirect = 1'b1;
        #1;
        ctl("redir_ctl", 4'b1111);
        tick();
        chk("redir_fwd", int'(fwd_sel), 0);
        redirect = 1'b0;
        drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        ctl("flush2_ctl", 4'b1111);
        tick();
        chk("flush2_fwd", int'(fwd_sel), 0);
        chk("flush_cnt", int'(stall_cnt), exp_cnt);
        #1;
        ctl("post_flush_ctl", 4'b1100);
        tick();
        chk("post_flush_fwd", int'(fwd_sel), 1);

        // saturation of the stall counter
        rst_n = 1'b0;
        #1;
        chk("rst_fwd", int'(fwd_sel), 0);
        rst_n = 1'b1;
        drive(1'b1, 5'd0, 5'd7, 2'b10, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0);
        repeat (14) tick();
        chk("sat_14", int'(stall_cnt), 14);
        tick();
        chk("sat_15", int'(stall_cnt), 15);
        tick();
        tick();
        chk("sat_hold", int'(stall_cnt), 15);
        ctl("sat_ctl", 4'b0001);

        // reset asserted mid-flush
        idle();
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        #1;
        ctl("midflush_ctl", 4'b1111);
        rst_n = 1'b0;
        #1;
        ctl("midflush_rst_ctl", 4'b0001);
        chk("midflush_rst_cnt", int'(stall_cnt), 0);
        rst_n = 1'b1;
        #1;
        ctl("midflush_after", 4'b1100);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
